// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a single UART transmit byte stream.
// Ownership is held until a last-flagged byte is accepted or the owner idles past a timeout.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned PRIORITY_RR    = 1
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [1:0] grant,
   output logic       timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_owner_q, last_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_d;
   logic             own_valid, own_last, own_ready, accept;
   logic [7:0]       own_data;

   // Current owner's request channel
   always_comb begin
      own_valid = req0_valid;
      own_data  = req0_data;
      own_last  = req0_last;
      if (owner_q) begin
         own_valid = req1_valid;
         own_data  = req1_data;
         own_last  = req1_last;
      end
   end

   // Owner may push whenever the output buffer is empty or draining this cycle
   assign own_ready = (state_q == OWN) && (!tx_valid || tx_ready);
   assign accept    = own_valid && own_ready;

   // State register
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arbitration, packet release and inactivity timeout
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      timeout_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req0_valid || req1_valid) begin
               state_d = OWN;
               if (PRIORITY_RR != 0) begin
                  owner_d = (req0_valid && req1_valid) ? !last_owner_q : req1_valid;
               end else begin
                  owner_d = !req0_valid;
               end
            end
         end
         OWN: begin
            // An accepted byte always beats a coincident timeout
            if (accept) begin
               cnt_d = '0;
               if (own_last) begin
                  state_d      = IDLE;
                  last_owner_d = owner_q;
               end
            end else if (!own_valid) begin
               if (cnt_q == CNT_LAST) begin
                  state_d      = IDLE;
                  last_owner_d = owner_q;
                  cnt_d        = '0;
                  timeout_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: only the owner sees ready
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (own_ready) begin
         if (owner_q) begin
            req1_ready = 1'b1;
         end else begin
            req0_ready = 1'b1;
         end
      end
   end

   // Control registers and one-entry output buffer
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cnt_q        <= '0;
         grant        <= 2'b00;
         timeout      <= 1'b0;
         tx_valid     <= 1'b0;
         tx_data      <= 8'h00;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         timeout      <= timeout_d;
         grant        <= (state_d == OWN) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
         if (accept) begin
            tx_valid <= 1'b1;
            tx_data  <= own_data;
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: round-robin and fixed-priority instances share stimulus,
// expected byte order comes from a packet-level arbitration model.
module tb_uart_tx_arbiter;

   localparam int unsigned TO     = 8;
   localparam int          BUDGET = 200;

   logic       HCLK   = 1'b0;
   logic       HRESET = 1'b1;
   logic       r0v, r0l, r1v, r1l, tx_ready;
   logic [7:0] r0d, r1d;

   logic       rr_r0_ready, rr_r1_ready, rr_tx_valid, rr_timeout;
   logic [7:0] rr_tx_data;
   logic [1:0] rr_grant;
   logic       fp_r0_ready, fp_r1_ready, fp_tx_valid, fp_timeout;
   logic [7:0] fp_tx_data;
   logic [1:0] fp_grant;

   logic       sel_fp = 1'b0;
   logic       m_r0_ready, m_r1_ready, m_tx_valid, m_timeout;
   logic [7:0] m_tx_data;
   logic [1:0] m_grant;

   int         tests  = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       last_owner_m = 1'b1;
   bit         rand_rdy = 1'b0;

   always #5 HCLK = ~HCLK;

   uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .PRIORITY_RR(1)) dut_rr (
      .HCLK(HCLK), .HRESET(HRESET),
      .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(rr_r0_ready),
      .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(rr_r1_ready),
      .tx_data(rr_tx_data), .tx_valid(rr_tx_valid), .tx_ready(tx_ready),
      .grant(rr_grant), .timeout(rr_timeout)
   );

   uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .PRIORITY_RR(0)) dut_fp (
      .HCLK(HCLK), .HRESET(HRESET),
      .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(fp_r0_ready),
      .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(fp_r1_ready),
      .tx_data(fp_tx_data), .tx_valid(fp_tx_valid), .tx_ready(tx_ready),
      .grant(fp_grant), .timeout(fp_timeout)
   );

   assign m_r0_ready = sel_fp ? fp_r0_ready : rr_r0_ready;
   assign m_r1_ready = sel_fp ? fp_r1_ready : rr_r1_ready;
   assign m_tx_valid = sel_fp ? fp_tx_valid : rr_tx_valid;
   assign m_tx_data  = sel_fp ? fp_tx_data  : rr_tx_data;
   assign m_grant    = sel_fp ? fp_grant    : rr_grant;
   assign m_timeout  = sel_fp ? fp_timeout  : rr_timeout;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
      if (r == 0) begin
         r0v = v; r0d = d; r0l = l;
      end else begin
         r1v = v; r1d = d; r1l = l;
      end
   endtask

   // Presents one requester's bytes, honouring ready; optional idle gaps inside the packet
   task automatic drive_pkt(input int r, input logic [7:0] d[$], input bit all_last, input int max_gap);
      for (int i = 0; i < d.size(); i++) begin
         bit acc;
         int waited;
         if (i > 0 && max_gap > 0) begin
            repeat ($urandom_range(max_gap, 0)) begin
               set_req(r, 1'b0, 8'h00, 1'b0);
               tick();
            end
         end
         set_req(r, 1'b1, d[i], all_last || (i == d.size() - 1));
         acc    = 1'b0;
         waited = 0;
         while (!acc && waited < BUDGET) begin
            @(negedge HCLK);
            acc = (r == 0) ? m_r0_ready : m_r1_ready;
            tick();
            waited++;
         end
         if (!acc) begin
            tests++;
            errors++;
            $display("FAIL accept_wait: requester %0d byte %0d not accepted within %0d cycles", r, i, BUDGET);
            break;
         end
      end
      set_req(r, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic push_bytes(input logic [7:0] d[$]);
      foreach (d[i]) exp_q.push_back(d[i]);
   endtask

   // Model: one packet per requester offered from idle at the same time
   task automatic contend(input logic [7:0] d0[$], input logic [7:0] d1[$], input int gap);
      int win;
      win = (sel_fp || last_owner_m) ? 0 : 1;
      if (win == 0) begin
         push_bytes(d0); push_bytes(d1); last_owner_m = 1'b1;
      end else begin
         push_bytes(d1); push_bytes(d0); last_owner_m = 1'b0;
      end
      fork
         drive_pkt(0, d0, 1'b0, gap);
         drive_pkt(1, d1, 1'b0, gap);
      join
   endtask

   task automatic single(input int r, input logic [7:0] d[$], input int gap);
      push_bytes(d);
      last_owner_m = (r != 0);
      drive_pkt(r, d, 1'b0, gap);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      tx_ready = 1'b1;
      while (exp_q.size() != 0 && w < BUDGET) begin
         tick();
         w++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      tx_ready = 1'b0;
      tick();
      @(negedge HCLK);
      check("rst_grant",    32'(m_grant),    32'd0);
      check("rst_tx_valid", 32'(m_tx_valid), 32'd0);
      check("rst_tx_data",  32'(m_tx_data),  32'd0);
      check("rst_timeout",  32'(m_timeout),  32'd0);
      check("rst_r0_ready", 32'(m_r0_ready), 32'd0);
      check("rst_r1_ready", 32'(m_r1_ready), 32'd0);
      tick();
      HRESET       = 1'b0;
      last_owner_m = 1'b1;
      exp_q.delete();
   endtask

   // Monitor: scoreboard pops on every UART handshake, plus hold and ready-ownership invariants
   initial begin
      bit         hold_v;
      logic [7:0] hold_d;
      logic [7:0] e;
      hold_v = 1'b0;
      hold_d = 8'h00;
      forever begin
         @(negedge HCLK);
         if (HRESET) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check("tx_hold_valid", 32'(m_tx_valid), 32'd1);
               check("tx_hold_data",  32'(m_tx_data),  32'(hold_d));
            end
            hold_v = m_tx_valid && !tx_ready;
            hold_d = m_tx_data;
            check("ready_owner", 32'((m_r0_ready && m_grant != 2'b01) || (m_r1_ready && m_grant != 2'b10)), 32'd0);
            if (m_tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  errors++;
                  $display("FAIL tx_unexpected: got byte %0h with empty scoreboard", m_tx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_byte", 32'(m_tx_data), 32'(e));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      int         len;
      int         g1_cnt;
      bit         r0_busy;

      r0v = 1'b0; r0d = 8'h00; r0l = 1'b0;
      r1v = 1'b0; r1d = 8'h00; r1l = 1'b0;
      tx_ready = 1'b0;
      do_reset();

      // 1: single packet latency and release
      tx_ready = 1'b1;
      qa = {8'h41, 8'h42, 8'h43};
      push_bytes(qa);
      set_req(0, 1'b1, 8'h41, 1'b0);
      @(negedge HCLK); check("t1_grant_idle", 32'(m_grant), 32'd0);
      tick();
      @(negedge HCLK); check("t1_grant_n1", 32'(m_grant), 32'd1);
      check("t1_ready_n1", 32'(m_r0_ready), 32'd1);
      tick(); set_req(0, 1'b1, 8'h42, 1'b0);
      @(negedge HCLK); check("t1_tx_n2", 32'({m_tx_valid, m_tx_data}), 32'h141);
      tick(); set_req(0, 1'b1, 8'h43, 1'b1);
      @(negedge HCLK); check("t1_tx_n3", 32'({m_tx_valid, m_tx_data}), 32'h142);
      tick(); set_req(0, 1'b0, 8'h00, 1'b0);
      @(negedge HCLK); check("t1_tx_n4", 32'({m_tx_valid, m_tx_data}), 32'h143);
      check("t1_grant_release", 32'(m_grant), 32'd0);
      tick();

      // 2: round-robin contention, twice
      wait_drain(); do_reset(); tx_ready = 1'b1;
      qa = {8'h10, 8'h11}; qb = {8'h20, 8'h21};
      contend(qa, qb, 0);
      qa = {8'h12, 8'h13}; qb = {8'h22};
      contend(qa, qb, 0);

      // 3: backpressure holds the buffered byte
      wait_drain(); do_reset(); tx_ready = 1'b0;
      qa = {8'h55, 8'h56};
      push_bytes(qa);
      fork
         drive_pkt(0, qa, 1'b0, 0);
         begin
            tick(); tick();
            for (int k = 0; k < 5; k++) begin
               @(negedge HCLK);
               check("t3_hold", 32'({m_tx_valid, m_tx_data}), 32'h155);
               check("t3_owner_ready", 32'(m_r0_ready), 32'd0);
               tick();
            end
            tx_ready = 1'b1;
         end
      join

      // 4: inactivity timeout hands over to req1
      wait_drain(); do_reset(); tx_ready = 1'b1;
      qb = {8'hBB, 8'hBC};
      exp_q.push_back(8'hAA);
      push_bytes(qb);
      last_owner_m = 1'b1;
      fork
         drive_pkt(1, qb, 1'b0, 0);
         begin
            set_req(0, 1'b1, 8'hAA, 1'b0);
            tick();
            tick(); set_req(0, 1'b0, 8'h00, 1'b0);
            for (int k = 2; k < 10; k++) begin
               @(negedge HCLK);
               check("t4_no_early_timeout", 32'(m_timeout), 32'd0);
               check("t4_grant_held", 32'(m_grant), 32'd1);
               tick();
            end
            @(negedge HCLK);
            check("t4_timeout_pulse", 32'(m_timeout), 32'd1);
            check("t4_grant_released", 32'(m_grant), 32'd0);
            tick();
            @(negedge HCLK);
            check("t4_timeout_once", 32'(m_timeout), 32'd0);
            check("t4_grant_req1", 32'(m_grant), 32'd2);
         end
      join

      // 5: fixed priority starves req1 while req0 streams packets
      wait_drain(); sel_fp = 1'b1; do_reset(); tx_ready = 1'b1;
      qa = {8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
      qb = {8'hE0};
      push_bytes(qa); push_bytes(qb);
      r0_busy = 1'b1;
      g1_cnt  = 0;
      fork
         begin drive_pkt(0, qa, 1'b1, 0); r0_busy = 1'b0; end
         drive_pkt(1, qb, 1'b1, 0);
         begin
            while (r0_busy) begin
               @(negedge HCLK);
               if (m_grant == 2'b10) g1_cnt++;
               tick();
            end
         end
      join
      check("t5_req1_never_granted", 32'(g1_cnt), 32'd0);

      // 6: reset mid-packet discards the buffered byte
      wait_drain(); sel_fp = 1'b0; do_reset();
      tx_ready = 1'b0;
      set_req(0, 1'b1, 8'h66, 1'b0);
      tick();
      tick();
      HRESET = 1'b1;
      @(negedge HCLK); check("t6_pre_tx_valid", 32'(m_tx_valid), 32'd1);
      tick();
      HRESET = 1'b0;
      set_req(0, 1'b0, 8'h00, 1'b0);
      @(negedge HCLK);
      check("t6_tx_valid", 32'(m_tx_valid), 32'd0);
      check("t6_grant",    32'(m_grant),    32'd0);
      check("t6_timeout",  32'(m_timeout),  32'd0);
      check("t6_ready",    32'({m_r1_ready, m_r0_ready}), 32'd0);
      last_owner_m = 1'b1;
      tx_ready = 1'b1;
      tick();
      qb = {8'h77};
      fork
         single(1, qb, 0);
         begin
            tick();
            @(negedge HCLK); check("t6_grant_req1", 32'(m_grant), 32'd2);
         end
      join

      // Randomized rounds with random UART backpressure
      wait_drain();
      rand_rdy = 1'b1;
      fork
         begin
            while (rand_rdy) begin
               tx_ready = ($urandom_range(9, 0) < 7);
               tick();
            end
         end
      join_none
      for (int n = 0; n < 30; n++) begin
         qa.delete(); qb.delete();
         len = $urandom_range(4, 1);
         repeat (len) qa.push_back(8'($urandom));
         len = $urandom_range(4, 1);
         repeat (len) qb.push_back(8'($urandom));
         if ($urandom_range(1, 0) == 1) contend(qa, qb, 2);
         else single(int'($urandom_range(1, 0)), qa, 2);
         repeat ($urandom_range(2, 0)) tick();
      end
      rand_rdy = 1'b0;
      tick(); tick();
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
